// File: rtl/vdu_bus_pkg.sv
// Shared definitions for the VDU host bus: FSM encoding, register map, bus widths.
package vdu_bus_pkg;

    // Bus widths
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;

    // VDU register address map
    localparam logic [ADDR_W-1:0] VDU_REG_DATA      = 4'h0;
    localparam logic [ADDR_W-1:0] VDU_REG_STATUS    = 4'h1;
    localparam logic [ADDR_W-1:0] VDU_REG_CURSOR    = 4'h2;
    localparam logic [ADDR_W-1:0] VDU_REG_CONTROL   = 4'h3;

    // Bus-cycle FSM encoding
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSetup  = 3'd1,
        StStrobe = 3'd2,
        StWait   = 3'd3,
        StHold   = 3'd4
    } vdu_state_e;

endpackage

// File: rtl/vdu_host_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// A load of N-1 therefore gives a phase lasting exactly N cycles.
module vdu_host_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // Load takes priority; otherwise count down and stop at zero
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/vdu_host.sv
// VDU host bus master: turns a valid/ready request into an ncs/nrd/nwr bus cycle
// with programmable setup, strobe and hold phases and wait_sig stretching.
// Optional feature macro: VDU_HOST_TIMEOUT_EN (abort a stretched WAIT with rsp_err).
module vdu_host
    import vdu_bus_pkg::*;
#(
    parameter int unsigned SETUP_CYC    = 1,
    parameter int unsigned STROBE_CYC   = 2,
    parameter int unsigned HOLD_CYC     = 1,
    parameter int unsigned WAIT_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              ncs,
    output logic              nrd,
    output logic              nwr,
    output logic [ADDR_W-1:0] ext_address,
    output logic [DATA_W-1:0] ext_data_out,
    output logic              ext_data_oe,
    input  logic [DATA_W-1:0] ext_data_in,
    input  logic              wait_sig
);

    if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : gen_bad_setup
        $error("SETUP_CYC out of range 1..15");
    end
    if (STROBE_CYC < 1 || STROBE_CYC > 15) begin : gen_bad_strobe
        $error("STROBE_CYC out of range 1..15");
    end
    if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : gen_bad_hold
        $error("HOLD_CYC out of range 1..15");
    end
    if (WAIT_TIMEOUT < 1 || WAIT_TIMEOUT > 255) begin : gen_bad_timeout
        $error("WAIT_TIMEOUT out of range 1..255");
    end

`ifdef VDU_HOST_TIMEOUT_EN
    localparam int unsigned CNT_W = 8;
`else
    localparam int unsigned CNT_W = 4;
`endif

    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYC - 1);
`ifdef VDU_HOST_TIMEOUT_EN
    localparam logic [CNT_W-1:0] WAIT_LOAD   = CNT_W'(WAIT_TIMEOUT - 1);
`else
    // WAIT is unbounded: the timer is simply left idle there
    localparam logic [CNT_W-1:0] WAIT_LOAD   = HOLD_LOAD;
`endif

    vdu_state_e       state;
    logic             write_q;
    logic             wait_q;
    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic             timer_done;
    logic             timeout_hit;
    logic             go_hold;

    vdu_host_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk      (clk),
        .nrst     (nrst),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    // Synchronise the responder's wait line before any decision uses it
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wait_q <= 1'b0;
        end else begin
            wait_q <= wait_sig;
        end
    end

`ifdef VDU_HOST_TIMEOUT_EN
    assign timeout_hit = timer_done;

    // Error flag is raised only alongside the completion pulse of an aborted WAIT
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rsp_err <= 1'b0;
        end else begin
            rsp_err <= (state == StWait) && wait_q && timer_done;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    assign req_ready = (state == StIdle);

    // Phase timer reloads and the decision to enter HOLD
    always_comb begin
        timer_load = 1'b0;
        timer_val  = '0;
        go_hold    = 1'b0;
        unique case (state)
            StIdle: begin
                timer_load = req_valid;
                timer_val  = SETUP_LOAD;
            end
            StSetup: begin
                timer_load = timer_done;
                timer_val  = STROBE_LOAD;
            end
            StStrobe: begin
                timer_load = timer_done;
                go_hold    = timer_done && !wait_q;
                timer_val  = wait_q ? WAIT_LOAD : HOLD_LOAD;
            end
            StWait: begin
                go_hold    = !wait_q || timeout_hit;
                timer_load = go_hold;
                timer_val  = HOLD_LOAD;
            end
            default: begin
                timer_load = 1'b0;
            end
        endcase
    end

    // Bus-cycle FSM with all bus and response outputs registered
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= StIdle;
            write_q      <= 1'b0;
            ncs          <= 1'b1;
            nrd          <= 1'b1;
            nwr          <= 1'b1;
            ext_address  <= '0;
            ext_data_out <= '0;
            ext_data_oe  <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (req_valid) begin
                        state       <= StSetup;
                        write_q     <= req_write;
                        ncs         <= 1'b0;
                        ext_address <= req_addr;
                        if (req_write) begin
                            ext_data_out <= req_wdata;
                            ext_data_oe  <= 1'b1;
                        end
                    end
                end
                StSetup: begin
                    if (timer_done) begin
                        state <= StStrobe;
                        nrd   <= write_q;
                        nwr   <= !write_q;
                    end
                end
                StStrobe: begin
                    if (timer_done && wait_q) begin
                        state <= StWait;
                    end
                end
                StWait: begin
                end
                StHold: begin
                    if (timer_done) begin
                        state       <= StIdle;
                        ncs         <= 1'b1;
                        ext_data_oe <= 1'b0;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase

            // Shared HOLD entry from STROBE or WAIT; wait_q still high means a timeout
            if (go_hold) begin
                state     <= StHold;
                nrd       <= 1'b1;
                nwr       <= 1'b1;
                rsp_valid <= 1'b1;
                if (wait_q) begin
                    rsp_rdata <= '0;
                end else if (!write_q) begin
                    rsp_rdata <= ext_data_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_vdu_host.sv
// Directed bench for vdu_host with a response scoreboard and a per-cycle bus-rule monitor.
`timescale 1ns/1ps
module tb_vdu_host;
    import vdu_bus_pkg::*;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_write = 1'b0;
    logic [3:0] req_addr = 4'h0;
    logic [7:0] req_wdata = 8'h00;
    logic       req_ready;
    logic       rsp_valid;
    logic       rsp_err;
    logic [7:0] rsp_rdata;
    logic       ncs;
    logic       nrd;
    logic       nwr;
    logic [3:0] ext_address;
    logic [7:0] ext_data_out;
    logic       ext_data_oe;
    logic [7:0] ext_data_in = 8'h00;
    logic       wait_sig = 1'b0;

    always #5 clk = ~clk;

    vdu_host #(
        .SETUP_CYC    (1),
        .STROBE_CYC   (2),
        .HOLD_CYC     (1),
        .WAIT_TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rsp_rdata    (rsp_rdata),
        .ncs          (ncs),
        .nrd          (nrd),
        .nwr          (nwr),
        .ext_address  (ext_address),
        .ext_data_out (ext_data_out),
        .ext_data_oe  (ext_data_oe),
        .ext_data_in  (ext_data_in),
        .wait_sig     (wait_sig)
    );

    typedef struct packed {
        logic       is_read;
        logic       err;
        logic [7:0] rdata;
    } rsp_t;

    rsp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   rsp_count = 0;
    int   ncs_falls = 0;
    logic ncs_prev = 1'b1;
    logic cur_write = 1'b0;

    function automatic rsp_t mk(input logic is_read, input logic err, input logic [7:0] rdata);
        rsp_t r;
        r.is_read = is_read;
        r.err     = err;
        r.rdata   = rdata;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; waits a bounded number of cycles for req_ready
    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait_bound", {31'd0, req_ready}, 32'd1);
    endtask

    // Present a request and return just after the accepting edge
    task automatic send(input logic wr, input logic [3:0] a, input logic [7:0] d,
                        input logic exp_rsp, input rsp_t e, input logic keep);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        wait_ready();
        cur_write = wr;
        if (exp_rsp) exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (!keep) req_valid = 1'b0;
    endtask

    // Scoreboard pop and bus rules, sampled mid-cycle
    always @(negedge clk) begin
        rsp_t e;
        logic proto_ok;
        if (nrst) begin
            if (ncs_prev && !ncs) ncs_falls++;
            ncs_prev = ncs;
            proto_ok = !(!nrd && !nwr) && !((!nrd || !nwr) && ncs)
                       && !(ext_data_oe && (ncs || !cur_write));
            if (!proto_ok)
                $display("bus state ncs=%b nrd=%b nwr=%b oe=%b", ncs, nrd, nwr, ext_data_oe);
            check("bus_rules", {31'd0, proto_ok}, 32'd1);
            if (rsp_valid) begin
                rsp_count++;
                check("rsp_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("sb_rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    if (e.is_read) check("sb_rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int snap_rsp;
        int snap_ncs;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ncs", {31'd0, ncs}, 32'd1);
        check("rst_nrd", {31'd0, nrd}, 32'd1);
        check("rst_nwr", {31'd0, nwr}, 32'd1);
        check("rst_oe", {31'd0, ext_data_oe}, 32'd0);
        check("rst_addr", {28'd0, ext_address}, 32'd0);
        check("rst_dout", {24'd0, ext_data_out}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
        nrst = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);

        // Write 0xA5 to reg 3, cycle-by-cycle timing after the accepting edge
        send(1'b1, VDU_REG_CONTROL, 8'hA5, 1'b1, mk(1'b0, 1'b0, 8'h00), 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("wr_ncs", {31'd0, ncs}, (k <= 4) ? 32'd0 : 32'd1);
            check("wr_nwr", {31'd0, nwr}, (k == 2 || k == 3) ? 32'd0 : 32'd1);
            check("wr_nrd", {31'd0, nrd}, 32'd1);
            check("wr_oe", {31'd0, ext_data_oe}, (k <= 4) ? 32'd1 : 32'd0);
            check("wr_rsp_valid", {31'd0, rsp_valid}, (k == 4) ? 32'd1 : 32'd0);
            check("wr_ready", {31'd0, req_ready}, (k == 5) ? 32'd1 : 32'd0);
            if (k <= 4) begin
                check("wr_dout", {24'd0, ext_data_out}, 32'hA5);
                check("wr_addr", {28'd0, ext_address}, 32'h3);
            end
            if (k == 4) check("wr_rsp_err", {31'd0, rsp_err}, 32'd0);
        end

        // Read 0x5C from reg 1
        ext_data_in = 8'h5C;
        send(1'b0, VDU_REG_STATUS, 8'h00, 1'b1, mk(1'b1, 1'b0, 8'h5C), 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("rd_nrd", {31'd0, nrd}, (k == 2 || k == 3) ? 32'd0 : 32'd1);
            check("rd_oe", {31'd0, ext_data_oe}, 32'd0);
            check("rd_rsp_valid", {31'd0, rsp_valid}, (k == 4) ? 32'd1 : 32'd0);
            if (k == 4) check("rd_rdata", {24'd0, rsp_rdata}, 32'h5C);
        end

        // Read stretched by wait_sig high for five sampled cycles from strobe start
        ext_data_in = 8'h11;
        send(1'b0, VDU_REG_CURSOR, 8'h00, 1'b1, mk(1'b1, 1'b0, 8'h9E), 1'b0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check("wt_nrd", {31'd0, nrd}, (k >= 2 && k <= 8) ? 32'd0 : 32'd1);
            check("wt_ncs", {31'd0, ncs}, (k <= 9) ? 32'd0 : 32'd1);
            check("wt_rsp_valid", {31'd0, rsp_valid}, (k == 9) ? 32'd1 : 32'd0);
            if (k == 9) begin
                check("wt_rdata", {24'd0, rsp_rdata}, 32'h9E);
                check("wt_rsp_err", {31'd0, rsp_err}, 32'd0);
            end
            if (k == 2) wait_sig = 1'b1;
            if (k == 7) begin
                wait_sig    = 1'b0;
                ext_data_in = 8'h9E;
            end
        end

`ifdef VDU_HOST_TIMEOUT_EN
        // wait_sig stuck high: abort after 16 WAIT cycles
        ext_data_in = 8'h77;
        send(1'b0, VDU_REG_STATUS, 8'h00, 1'b1, mk(1'b1, 1'b1, 8'h00), 1'b0);
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            check("to_nrd", {31'd0, nrd}, (k >= 2 && k <= 19) ? 32'd0 : 32'd1);
            check("to_rsp_valid", {31'd0, rsp_valid}, (k == 20) ? 32'd1 : 32'd0);
            if (k == 20) begin
                check("to_rsp_err", {31'd0, rsp_err}, 32'd1);
                check("to_rdata", {24'd0, rsp_rdata}, 32'h00);
            end
            if (k == 2) wait_sig = 1'b1;
        end
        wait_sig    = 1'b0;
        ext_data_in = 8'h3E;
        send(1'b0, VDU_REG_DATA, 8'h00, 1'b1, mk(1'b1, 1'b0, 8'h3E), 1'b0);
        repeat (6) @(negedge clk);
        check("to_recover_rdata", {24'd0, rsp_rdata}, 32'h3E);
`endif

        // Reset asserted during the strobe of a write abandons it silently
        snap_rsp = rsp_count;
        send(1'b1, VDU_REG_CONTROL, 8'h3C, 1'b0, mk(1'b0, 1'b0, 8'h00), 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("mr_in_strobe", {31'd0, nwr}, 32'd0);
        nrst = 1'b0;
        #1;
        check("mr_ncs", {31'd0, ncs}, 32'd1);
        check("mr_nwr", {31'd0, nwr}, 32'd1);
        check("mr_oe", {31'd0, ext_data_oe}, 32'd0);
        check("mr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mr_rdata", {24'd0, rsp_rdata}, 32'd0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        check("mr_ready", {31'd0, req_ready}, 32'd1);
        repeat (8) @(negedge clk);
        check("mr_no_rsp", rsp_count, snap_rsp);

        // Three writes with req_valid held high throughout
        snap_rsp = rsp_count;
        snap_ncs = ncs_falls;
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 4'(i + 4), 8'(8'h20 + i), 1'b1, mk(1'b0, 1'b0, 8'h00), 1'b1);
        end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("b2b_rsp_count", rsp_count - snap_rsp, 32'd3);
        check("b2b_bus_cycles", ncs_falls - snap_ncs, 32'd3);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vdu_host.md
VDU_HOST -- requirements
Module: vdu_host

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 1: cycles ncs/address are valid before the strobe (range 1..15).
REQ-002 SHALL have parameter STROBE_CYC, default 2: minimum cycles nrd/nwr are held low (range 1..15).
REQ-003 SHALL have parameter HOLD_CYC, default 1: cycles address/data/ncs are held after the strobe rises (range 1..15).
REQ-004 SHALL have parameter WAIT_TIMEOUT, default 16: maximum cycles spent waiting on wait_sig before abort (range 1..255).
REQ-005 SHALL use one clock and an asynchronous active-low reset: clk in 1, the single clock; nrst in 1, async active-low reset.
REQ-006 SHALL provide these ports:
- req_valid in 1: request present.
- req_write in 1: 1 = write, 0 = read.
- req_addr in 4: VDU register address.
- req_wdata in 8: write data.
- req_ready out 1: request accepted when high together with req_valid.
- rsp_valid out 1: one-cycle completion pulse.
- rsp_err out 1: completion aborted by timeout.
- rsp_rdata out 8: read data.
- ncs out 1, nrd out 1, nwr out 1: active-low bus controls.
- ext_address out 4: bus address.
- ext_data_out out 8: bus write data.
- ext_data_oe out 1: drive enable for the data pad.
- ext_data_in in 8: bus read data.
- wait_sig in 1: high = responder not ready.

Function
REQ-007 SHALL implement FSM states IDLE, SETUP, STROBE, WAIT, HOLD.
REQ-008 In IDLE, req_ready SHALL be 1; in all other states it SHALL be 0. A handshake SHALL register addr/write/wdata and move to SETUP.
REQ-009 In SETUP, ncs SHALL be 0 and ext_address valid. For writes, ext_data_oe SHALL be 1 with ext_data_out valid. nrd/nwr SHALL be 1. Duration SHALL be exactly SETUP_CYC cycles, then STROBE.
REQ-010 In STROBE, nrd (read) or nwr (write) SHALL be 0 for STROBE_CYC cycles. On the last cycle, if wait_sig = 0, go to HOLD; else go to WAIT.
REQ-011 In WAIT, the strobe SHALL stay low. The FSM SHALL go to HOLD on the first cycle in which the registered wait_sig is 0.
REQ-012 For reads, ext_data_in SHALL be captured into rsp_rdata on the cycle the FSM leaves STROBE/WAIT for HOLD without error.
REQ-013 In HOLD, strobes SHALL be 1 while ncs, address and write data are held. Duration SHALL be HOLD_CYC cycles, then IDLE, where ncs returns to 1.
REQ-014 rsp_valid SHALL pulse for exactly one cycle, on the first HOLD cycle, for both reads and writes.
REQ-015 wait_sig SHALL be passed through one synchronizing flop before use; this adds one cycle to WAIT exit.
REQ-016 ext_data_oe SHALL never be 1 during a read or in IDLE.
REQ-017 nrd and nwr SHALL never be 0 simultaneously, and no strobe SHALL ever be 0 while ncs is 1.
REQ-018 Back-to-back requests SHALL have at least one IDLE cycle with ncs = 1 between bus cycles.

Reset
REQ-019 Asserting nrst SHALL force, asynchronously: IDLE; ncs = nrd = nwr = 1; ext_data_oe = 0; ext_address = 0; ext_data_out = 0; rsp_valid = 0; rsp_err = 0; rsp_rdata = 0; counters = 0; req_ready = 1 after release.
REQ-020 Reset mid-cycle SHALL abandon the transfer with no rsp_valid.

Configuration
REQ-021 Macro VDU_HOST_TIMEOUT_EN:
- When defined, a WAIT lasting WAIT_TIMEOUT cycles SHALL go to HOLD with rsp_err = 1 and rsp_rdata = 0.
- When undefined, WAIT SHALL be unbounded, rsp_err SHALL be tied to 0, and no timeout counter SHALL exist.

Structure
REQ-022 Shared package vdu_bus_pkg SHALL hold:
- the FSM state encoding;
- VDU register address constants (4-bit);
- bus width constants (address 4, data 8).
REQ-023 One sub-module, vdu_host_timer, SHALL provide a loadable down-counter with a done flag, shared by the SETUP/STROBE/HOLD/timeout phases.

Verification
REQ-024 Write (defaults), addr 0x3, data 0xA5, wait_sig = 0 -> accept at T:
- ncs low T+1..T+4;
- nwr low T+2..T+3;
- ext_data_oe high T+1..T+4 with data 0xA5;
- rsp_valid at T+4, rsp_err = 0;
- req_ready high at T+5.
REQ-025 Read addr 0x1, ext_data_in = 0x5C, wait_sig = 0 -> nrd low 2 cycles, rsp_rdata = 0x5C with rsp_valid, ext_data_oe = 0 throughout.
REQ-026 Read with wait_sig high for 5 cycles from strobe start -> nrd low extended per REQ-015, data captured after wait_sig falls, rsp_err = 0.
REQ-027 With VDU_HOST_TIMEOUT_EN, wait_sig stuck high -> after 16 WAIT cycles: rsp_valid = 1, rsp_err = 1, rsp_rdata = 0x00; next request accepted normally.
REQ-028 nrst asserted during STROBE of a write -> same cycle ncs = nwr = 1, ext_data_oe = 0; no rsp_valid ever for that request.
REQ-029 req_valid held high with 3 queued writes -> 3 bus cycles, each separated by ≥1 cycle of ncs = 1, exactly 3 rsp_valid pulses.
